// File: rtl/eth_tx_arb.sv
// eth_tx_arb: two-source, frame-granular arbiter in front of the Ethernet TX
// frame path. The grant is held for a whole frame. The header is registered
// and the payload passes straight through. Frames longer than MAX_PAYLOAD are
// cut short: the cut beat is flagged as an error and the rest of the frame is
// discarded.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; arbitrate among header requests
// HDR     | registered header presented downstream, waiting for hdr_ready
// PAYLOAD | payload of the granted source passes through, beats counted
// DRAIN   | frame was truncated; swallow input beats up to tlast
module eth_tx_arb #(
    parameter int ARB_MODE    = 0,
    parameter int MAX_PAYLOAD = 1500,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_eth_hdr_valid,
    output logic        s0_eth_hdr_ready,
    input  logic [47:0] s0_eth_dest_mac,
    input  logic [47:0] s0_eth_src_mac,
    input  logic [15:0] s0_eth_type,
    input  logic [7:0]  s0_eth_payload_axis_tdata,
    input  logic        s0_eth_payload_axis_tvalid,
    output logic        s0_eth_payload_axis_tready,
    input  logic        s0_eth_payload_axis_tlast,
    input  logic        s0_eth_payload_axis_tuser,
    input  logic        s1_eth_hdr_valid,
    output logic        s1_eth_hdr_ready,
    input  logic [47:0] s1_eth_dest_mac,
    input  logic [47:0] s1_eth_src_mac,
    input  logic [15:0] s1_eth_type,
    input  logic [7:0]  s1_eth_payload_axis_tdata,
    input  logic        s1_eth_payload_axis_tvalid,
    output logic        s1_eth_payload_axis_tready,
    input  logic        s1_eth_payload_axis_tlast,
    input  logic        s1_eth_payload_axis_tuser,
    output logic        m_eth_hdr_valid,
    input  logic        m_eth_hdr_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [7:0]  m_eth_payload_axis_tdata,
    output logic        m_eth_payload_axis_tvalid,
    input  logic        m_eth_payload_axis_tready,
    output logic        m_eth_payload_axis_tlast,
    output logic        m_eth_payload_axis_tuser,
    output logic        grant,
    output logic        busy,
    output logic        trunc_pulse
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

    // Counter value seen while the MAX_PAYLOAD-th beat is on the bus.
    localparam int unsigned    LIMIT_M1 = (MAX_PAYLOAD > 0) ? MAX_PAYLOAD - 1 : 0;
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(LIMIT_M1);
    localparam bit             TRUNC_EN = (MAX_PAYLOAD != 0);

    state_t           state;
    state_t           state_nxt;
    logic             grant_r;
    logic             last_grant;
    logic [47:0]      dest_r;
    logic [47:0]      src_r;
    logic [15:0]      type_r;
    logic [CNT_W-1:0] cnt;

    logic       any_req;
    logic       win;
    logic [7:0] in_tdata;
    logic       in_tvalid;
    logic       in_tlast;
    logic       in_tuser;
    logic       trunc_beat;
    logic       pay_xfer;
    logic       src_tready;

    assign any_req = s0_eth_hdr_valid | s1_eth_hdr_valid;

    // Round-robin only matters when both request; otherwise the sole requester
    // wins, and fixed priority always favours port 0.
    assign win = (ARB_MODE == 0 && s0_eth_hdr_valid && s1_eth_hdr_valid) ?
                 ~last_grant : ~s0_eth_hdr_valid;

    assign in_tdata  = grant_r ? s1_eth_payload_axis_tdata  : s0_eth_payload_axis_tdata;
    assign in_tvalid = grant_r ? s1_eth_payload_axis_tvalid : s0_eth_payload_axis_tvalid;
    assign in_tlast  = grant_r ? s1_eth_payload_axis_tlast  : s0_eth_payload_axis_tlast;
    assign in_tuser  = grant_r ? s1_eth_payload_axis_tuser  : s0_eth_payload_axis_tuser;

    // A beat that lands on the limit but already ends the frame is not a cut.
    assign trunc_beat = TRUNC_EN && (cnt == LIMIT) && !in_tlast;
    assign pay_xfer   = (state == PAYLOAD) && in_tvalid && m_eth_payload_axis_tready;

    assign m_eth_dest_mac = dest_r;
    assign m_eth_src_mac  = src_r;
    assign m_eth_type     = type_r;
    assign grant          = grant_r;
    assign busy           = (state != IDLE);

    // Next-state decode and all handshake/stream outputs.
    always_comb begin
        state_nxt                 = state;
        s0_eth_hdr_ready          = 1'b0;
        s1_eth_hdr_ready          = 1'b0;
        m_eth_hdr_valid           = 1'b0;
        m_eth_payload_axis_tdata  = 8'h00;
        m_eth_payload_axis_tvalid = 1'b0;
        m_eth_payload_axis_tlast  = 1'b0;
        m_eth_payload_axis_tuser  = 1'b0;
        trunc_pulse               = 1'b0;
        src_tready                = 1'b0;
        case (state)
            IDLE: begin
                // Held off during reset so no source sees a phantom accept.
                if (any_req && !rst) begin
                    s0_eth_hdr_ready = ~win;
                    s1_eth_hdr_ready = win;
                    state_nxt        = HDR;
                end
            end
            HDR: begin
                m_eth_hdr_valid = 1'b1;
                if (m_eth_hdr_ready) begin
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_eth_payload_axis_tdata  = in_tdata;
                m_eth_payload_axis_tvalid = in_tvalid;
                m_eth_payload_axis_tlast  = in_tlast | trunc_beat;
                m_eth_payload_axis_tuser  = in_tuser | trunc_beat;
                src_tready                = m_eth_payload_axis_tready;
                if (pay_xfer) begin
                    if (trunc_beat) begin
                        trunc_pulse = 1'b1;
                        state_nxt   = DRAIN;
                    end else if (in_tlast) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                src_tready = 1'b1;
                if (in_tvalid && in_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        s0_eth_payload_axis_tready = src_tready & ~grant_r;
        s1_eth_payload_axis_tready = src_tready & grant_r;
    end

    // State, grant bookkeeping, header capture and saturating beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_r    <= 1'b0;
            last_grant <= 1'b1;
            dest_r     <= 48'h0;
            src_r      <= 48'h0;
            type_r     <= 16'h0;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                grant_r <= win;
                dest_r  <= win ? s1_eth_dest_mac : s0_eth_dest_mac;
                src_r   <= win ? s1_eth_src_mac  : s0_eth_src_mac;
                type_r  <= win ? s1_eth_type     : s0_eth_type;
            end
            if (state == HDR && m_eth_hdr_ready) begin
                cnt <= '0;
            end else if (pay_xfer && !(&cnt)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state != IDLE && state_nxt == IDLE) begin
                last_grant <= grant_r;
            end
        end
    end

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Two-port, frame-granular arbiter sharing one Ethernet TX frame path (header plus 8-bit payload AXI-stream) between two frame sources.
- Typical sources: the ddr-sourced frame packer output and a second frame generator (e.g. ARP/status). Sits in the eth_clk domain, directly in front of the eth_frame_tx/MAC stage.
- Locks the grant for a whole frame, registers the header, passes payload through combinationally, and truncates over-length frames.

Parameters:
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 wins).
- MAX_PAYLOAD, 1500, payload byte limit per frame; 0 disables truncation.
- CNT_W, 16, width of the payload beat counter.

Ports:
- clk  in  1  eth clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s{0,1}_eth_hdr_valid  in  1  header request per source.
- s{0,1}_eth_hdr_ready  out  1  header accepted (one-cycle pulse on grant).
- s{0,1}_eth_dest_mac  in  48  destination MAC.
- s{0,1}_eth_src_mac  in  48  source MAC.
- s{0,1}_eth_type  in  16  EtherType.
- s{0,1}_eth_payload_axis_tdata  in  8  payload byte.
- s{0,1}_eth_payload_axis_tvalid  in  1  payload valid.
- s{0,1}_eth_payload_axis_tready  out  1  payload ready.
- s{0,1}_eth_payload_axis_tlast  in  1  last payload byte.
- s{0,1}_eth_payload_axis_tuser  in  1  frame error flag.
- m_eth_hdr_valid / m_eth_hdr_ready  out / in  1  output header handshake.
- m_eth_dest_mac, m_eth_src_mac, m_eth_type  out  48, 48, 16  registered header fields.
- m_eth_payload_axis_tdata / tvalid / tready / tlast / tuser  out / out / in / out / out  8 / 1 / 1 / 1 / 1  payload stream.
- grant  out  1  index of the port owning the path (valid while busy).
- busy  out  1  high in any state other than IDLE.
- trunc_pulse  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset: state = IDLE; all valid/ready/tlast/tuser outputs = 0; header registers = 0; grant = 0; last_grant = 1, so port 0 wins the first round-robin decision; beat counter = 0.
- Reset asserted mid-frame returns to IDLE on that edge. The partial frame is abandoned; upstream sources are reset by the same rst.
- **IDLE**
  - If any sX_eth_hdr_valid is high, pick a winner.
  - Round-robin: if both request, the port != last_grant wins; otherwise the sole requester wins.
  - Fixed priority: port 0 wins whenever it requests.
  - In the decision cycle the winner's sX_eth_hdr_ready = 1 (combinational). Header fields are latched and grant is set, then go to HDR. The loser's hdr_ready stays 0.
- **HDR**
  - m_eth_hdr_valid = 1, starting the cycle after acceptance (1-cycle latency).
  - Header fields are held stable until m_eth_hdr_ready.
  - On the m_eth_hdr_valid & m_eth_hdr_ready edge go to PAYLOAD; counter = 0.
- **PAYLOAD**
  - Pass-through: m_tdata/tvalid/tlast/tuser = granted source; granted sX_tready = m_tready.
  - Non-granted tready = 0; both hdr_ready = 0.
  - Each transfer increments the counter.
  - A transfer with input tlast goes to IDLE and sets last_grant = grant. The next arbitration can occur in the following cycle, so there is no dead cycle beyond IDLE.
  - Truncation: if MAX_PAYLOAD != 0, the current transfer is beat number MAX_PAYLOAD, and input tlast = 0, then on that beat force m_tlast = 1 and m_tuser = 1, pulse trunc_pulse, and go to DRAIN.
  - A beat exactly at MAX_PAYLOAD that carries tlast is normal: no truncation.
- **DRAIN**
  - m_tvalid = 0; granted sX_tready = 1; input beats are discarded.
  - On an input beat with tlast go to IDLE and set last_grant = grant.
- Counter saturates at its maximum and never wraps.
- Zero-length frames are not supported: the first payload beat may carry tlast (1-byte frame).
- Input tvalid during HDR is ignored: tready = 0 until PAYLOAD.

Test Plan:
- Single source: port 0 sends header (dest 0x0A..., type 0x0800) plus 4 bytes 0x11–0x14 with tlast on 0x14. Expect: m_hdr_valid one cycle after s0_hdr_ready; identical bytes out; tlast on the 4th byte; s1 ready always 0.
- Both request simultaneously after reset, ARB_MODE = 0, 3 frames each. Expect grant order 0, 1, 0, 1, 0, 1 and no interleaved bytes. With ARB_MODE = 1, all port-0 frames go first.
- Backpressure: m_hdr_ready is held low 5 cycles, then m_tready toggles 1/0. Expect header fields stable and no byte lost or duplicated.
- MAX_PAYLOAD = 8 with a 12-byte frame. Expect 8 bytes out, 8th with tlast = 1 and tuser = 1, trunc_pulse once, remaining 4 bytes consumed with m_tvalid = 0, then IDLE.
- MAX_PAYLOAD = 8 with an exactly 8-byte frame: no trunc_pulse and tuser follows input (0).
- rst asserted during PAYLOAD beat 3: next cycle busy = 0 and all outputs at reset values. The next frame from port 0 is granted first.
